// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 9-bit CPU: owns the PC and the return stack.
// Define SEQ_CYCLE_COUNT_EN to build the saturating active-cycle counter on cycle_cnt.
module cpu_sequencer #(
    parameter int PC_W  = 10,
    parameter int STK_D = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            done_i,
    input  logic            load_en,
    input  logic            stor_en,
    input  logic            jump2sub,
    input  logic            ret_i,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_tgt,
    input  logic [PC_W-1:0] sub_tgt,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            imem_en,
    output logic            ir_we,
    output logic            exec_en,
    output logic            mem_req,
    output logic            done,
    output logic            stk_err,
    output logic [15:0]     cycle_cnt
);
    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

    state_t            state;
    logic [SP_W-1:0]   sp;
    logic [PC_W-1:0]   stk [STK_D];
    logic              stk_full, stk_empty, do_push;
    logic [IDX_W-1:0]  push_idx, top_idx;

    assign stk_full  = (sp == SP_W'(STK_D));
    assign stk_empty = (sp == '0);
    assign push_idx  = IDX_W'(sp);
    assign top_idx   = IDX_W'(sp - SP_W'(1));
    assign do_push   = (state == EXEC) && !done_i && !(load_en | stor_en) && jump2sub && !stk_full;

    // Stack storage needs no reset: the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) stk[push_idx] <= pc + PC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            sp      <= '0;
            imem_en <= 1'b0;
            ir_we   <= 1'b0;
            exec_en <= 1'b0;
            mem_req <= 1'b0;
            done    <= 1'b0;
            stk_err <= 1'b0;
        end else begin
            imem_en <= 1'b0;
            ir_we   <= 1'b0;
            exec_en <= 1'b0;
            mem_req <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pc      <= '0;
                    sp      <= '0;
                    stk_err <= 1'b0;
                    imem_en <= 1'b1;
                    state   <= FETCH;
                end
                FETCH: begin
                    ir_we <= 1'b1;
                    state <= DECODE;
                end
                DECODE: begin
                    exec_en <= 1'b1;
                    state   <= EXEC;
                end
                EXEC: begin
                    // Strobes are registered, so each branch raises the next state's strobe.
                    if (done_i) begin
                        done  <= 1'b1;
                        state <= HALT;
                    end else if (load_en | stor_en) begin
                        mem_req <= 1'b1;
                        state   <= MEM;
                    end else if (jump2sub && stk_full) begin
                        stk_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= HALT;
                    end else if (jump2sub) begin
                        sp      <= sp + SP_W'(1);
                        pc      <= sub_tgt;
                        imem_en <= 1'b1;
                        state   <= FETCH;
                    end else if (ret_i && stk_empty) begin
                        stk_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= HALT;
                    end else if (ret_i) begin
                        sp      <= sp - SP_W'(1);
                        pc      <= stk[top_idx];
                        imem_en <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        pc      <= br_taken ? br_tgt : pc + PC_W'(1);
                        imem_en <= 1'b1;
                        state   <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        pc      <= pc + PC_W'(1);
                        imem_en <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                HALT: if (!start) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
        end else if ((state == FETCH || state == DECODE || state == EXEC || state == MEM) &&
                     cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`else
    assign cycle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized programs against an
// instruction-level model (PC, queue-based return stack, cycle budget per instruction).
module tb_cpu_sequencer;
    localparam int PC_W  = 10;
    localparam int STK_D = 4;

    logic            clk = 1'b0;
    logic            reset, start, done_i, load_en, stor_en, jump2sub, ret_i, br_taken, mem_ack;
    logic [PC_W-1:0] br_tgt, sub_tgt, pc;
    logic            imem_en, ir_we, exec_en, mem_req, done, stk_err;
    logic [15:0]     cycle_cnt;

    cpu_sequencer #(.PC_W(PC_W), .STK_D(STK_D)) dut (
        .clk(clk), .reset(reset), .start(start), .done_i(done_i), .load_en(load_en),
        .stor_en(stor_en), .jump2sub(jump2sub), .ret_i(ret_i), .br_taken(br_taken),
        .br_tgt(br_tgt), .sub_tgt(sub_tgt), .mem_ack(mem_ack), .pc(pc), .imem_en(imem_en),
        .ir_we(ir_we), .exec_en(exec_en), .mem_req(mem_req), .done(done), .stk_err(stk_err),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int              n_tests = 0, n_fail = 0;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_stk [$];
    logic            m_err, m_halt;
    int              m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cnt();
`ifdef SEQ_CYCLE_COUNT_EN
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
`else
        chk("cycle_cnt0", 32'(cycle_cnt), 32'd0);
`endif
    endtask

    task automatic adv(input bit active);
        if (active && m_cnt < 65535) m_cnt++;
        @(negedge clk);
    endtask

    task automatic clr_dec();
        {done_i, load_en, stor_en, jump2sub, ret_i, br_taken, mem_ack} = '0;
    endtask

    // Decoder lines are only meaningful in EXEC; scribble on them elsewhere.
    task automatic junk();
        {done_i, load_en, stor_en, jump2sub, ret_i, br_taken, mem_ack} = 7'($urandom);
        br_tgt  = PC_W'($urandom);
        sub_tgt = PC_W'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        adv(0);
        m_pc = '0; m_stk.delete(); m_err = 1'b0; m_cnt = 0; m_halt = 1'b0;
        chk("start_imem", 32'(imem_en), 32'd1);
        chk("start_pc", 32'(pc), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(stk_err), 32'd0);
        chk_cnt();
    endtask

    // One instruction from its FETCH cycle; leaves the bench at the next FETCH or in HALT.
    task automatic instr(input bit dn, ld, st, js, rt, bt,
                         input logic [PC_W-1:0] bt_t, st_t, input int nack);
        chk("f_imem", 32'(imem_en), 32'd1);
        chk("f_pc", 32'(pc), 32'(m_pc));
        chk("f_ir", 32'(ir_we), 32'd0);
        chk_cnt();
        junk(); mem_ack = 1'b1;
        adv(1);
        chk("d_ir", 32'(ir_we), 32'd1);
        chk("d_exec", 32'(exec_en), 32'd0);
        junk();
        adv(1);
        chk("e_exec", 32'(exec_en), 32'd1);
        chk("e_ir", 32'(ir_we), 32'd0);
        done_i = dn; load_en = ld; stor_en = st; jump2sub = js; ret_i = rt; br_taken = bt;
        br_tgt = bt_t; sub_tgt = st_t; mem_ack = 1'($urandom);
        adv(1);
        clr_dec();
        if (dn) begin
            m_halt = 1'b1;
        end else if (ld || st) begin
            for (int k = 0; k < nack; k++) begin
                chk("m_req", 32'(mem_req), 32'd1);
                chk("m_imem", 32'(imem_en), 32'd0);
                chk("m_pc", 32'(pc), 32'(m_pc));
                mem_ack = (k == nack - 1);
                adv(1);
            end
            mem_ack = 1'b0;
            m_pc = m_pc + 1'b1;
        end else if (js) begin
            if (m_stk.size() == STK_D) begin m_err = 1'b1; m_halt = 1'b1; end
            else begin m_stk.push_back(m_pc + 1'b1); m_pc = st_t; end
        end else if (rt) begin
            if (m_stk.size() == 0) begin m_err = 1'b1; m_halt = 1'b1; end
            else m_pc = m_stk.pop_back();
        end else if (bt) begin
            m_pc = bt_t;
        end else begin
            m_pc = m_pc + 1'b1;
        end
        chk("x_req", 32'(mem_req), 32'd0);
        chk("x_done", 32'(done), 32'(m_halt));
        chk("x_err", 32'(stk_err), 32'(m_err));
        if (m_halt) begin
            chk("h_pc", 32'(pc), 32'(m_pc));
            chk("h_imem", 32'(imem_en), 32'd0);
            chk_cnt();
        end
    endtask

    task automatic plain();
        instr(0, 0, 0, 0, 0, 0, '0, '0, 1);
    endtask

    // Start held high keeps HALT; dropping it returns to IDLE.
    task automatic finish_prog();
        for (int i = 0; i < 3; i++) begin
            adv(0);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_imem", 32'(imem_en), 32'd0);
        end
        chk_cnt();
        start = 1'b0;
        adv(0);
        chk("idle_done", 32'(done), 32'd0);
        adv(0);
        chk("idle_imem", 32'(imem_en), 32'd0);
        chk("idle_err", 32'(stk_err), 32'(m_err));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clr_dec(); br_tgt = '0; sub_tgt = '0;
        m_pc = '0; m_err = 1'b0; m_halt = 1'b0; m_cnt = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_strobes", 32'({imem_en, ir_we, exec_en, mem_req, done, stk_err}), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        reset = 1'b0;
        adv(0);

        // three plain instructions, then halt
        do_start();
        plain(); plain(); plain();
        instr(1, 0, 0, 0, 0, 0, '0, '0, 1);
        finish_prog();

        // load with delayed ack, spurious ack in the next FETCH
        do_start();
        instr(0, 1, 0, 0, 0, 0, '0, '0, 3);
        plain();
        instr(0, 0, 1, 0, 0, 0, '0, '0, 1);
        instr(1, 0, 0, 0, 0, 0, '0, '0, 1);
        finish_prog();

        // call at 5 to 0x40 and return to 6
        do_start();
        instr(0, 0, 0, 0, 0, 1, PC_W'(5), '0, 1);
        instr(0, 0, 0, 1, 0, 0, '0, PC_W'(10'h40), 1);
        instr(0, 0, 0, 0, 1, 0, '0, '0, 1);
        instr(1, 0, 0, 0, 0, 0, '0, '0, 1);
        finish_prog();

        // stack overflow on the fifth nested call
        do_start();
        for (int i = 0; i < 5; i++) instr(0, 0, 0, 1, 0, 0, '0, PC_W'(16 * (i + 1)), 1);
        finish_prog();

        // underflow, then restart clears stk_err; also PC wrap
        do_start();
        instr(0, 0, 0, 0, 1, 0, '0, '0, 1);
        finish_prog();
        do_start();
        instr(0, 0, 0, 0, 0, 1, PC_W'(10'h3FF), '0, 1);
        plain();
        instr(0, 1, 0, 0, 0, 0, '0, '0, 1);
        instr(1, 0, 0, 0, 0, 0, '0, '0, 1);
        finish_prog();

        // async reset in the middle of a memory wait
        do_start();
        instr(0, 0, 0, 0, 0, 1, PC_W'(10'h123), '0, 1);
        chk("pre_pc", 32'(pc), 32'h123);
        adv(1); adv(1);
        load_en = 1'b1;
        adv(1);
        clr_dec();
        chk("mw_req", 32'(mem_req), 32'd1);
        adv(1);
        chk("mw_req2", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_pc", 32'(pc), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_cnt", 32'(cycle_cnt), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        adv(0);
        chk("ar_idle", 32'(imem_en), 32'd0);

        // randomized programs
        for (int run = 0; run < 30; run++) begin
            do_start();
            for (int i = 0; i < 25 && !m_halt; i++) begin
                instr(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 10),
                      ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 25),
                      ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 40),
                      PC_W'($urandom), PC_W'($urandom), int'($urandom_range(1, 4)));
            end
            if (!m_halt) instr(1, 0, 0, 0, 0, 0, '0, '0, 1);
            finish_prog();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
